// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst helpers.
// Used by the bus arbiter and the slave interface.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   // Beats remaining after the NONSEQ; zero for SINGLE and open INCR
   function automatic logic [3:0] burst_len_m1(input hburst_e b);
      logic [3:0] n;
      unique case (b)
         HBURST_WRAP4, HBURST_INCR4:   n = 4'd3;
         HBURST_WRAP8, HBURST_INCR8:   n = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
         default:                      n = 4'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating-priority encoder: first request after ptr wins.
// Pure combinational, one-hot result plus any-request flag.
module ahb_rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          valid
);

   always_comb begin
      logic [IW:0]   s;
      logic [IW-1:0] k;
      logic          found;
      gnt   = '0;
      found = 1'b0;
      s     = '0;
      k     = '0;
      for (int i = 1; i <= N; i++) begin
         s = {1'b0, ptr} + (IW+1)'(i);
         if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
         k = s[IW-1:0];
         if (!found && req[k]) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant with burst, INCR and lock hold.
// All outputs registered and frozen while HREADY is low.
module ahb_bus_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                           ahb_clk_in,
   input  logic                           ahb_rstn_in,
   input  logic [NUM_MASTERS-1:0]         mst_req_in,
   input  logic [NUM_MASTERS-1:0]         mst_lock_in,
   input  logic [1:0]                     ahb_trans_in,
   input  logic [2:0]                     ahb_burst_in,
   input  logic                           ahb_ready_in,
   output logic [NUM_MASTERS-1:0]         mst_grant_out,
   output logic [$clog2(NUM_MASTERS)-1:0] addr_master_out,
   output logic [$clog2(NUM_MASTERS)-1:0] data_master_out,
   output logic                           ahb_mastlock_out
);

   localparam int IW = $clog2(NUM_MASTERS);
   localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_GNT =
      NUM_MASTERS'(1) << DEFAULT_MASTER;

   localparam logic [1:0] ST_ARB    = 2'd0;
   localparam logic [1:0] ST_BURST  = 2'd1;
   localparam logic [1:0] ST_INCR   = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   logic [1:0]             st_q, st_n;
   logic [3:0]             cnt_q, cnt_n;
   logic [IW-1:0]          addr_q, data_q, ptr_q;
   logic [IW-1:0]          win_idx, new_idx;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_n, pick_gnt;
   logic                   pick_valid, lock_q, rearb;
   logic                   lock_own, req_own;
   htrans_e                trans;
   hburst_e                burst;
   logic [3:0]             blen;

   assign trans    = htrans_e'(ahb_trans_in);
   assign burst    = hburst_e'(ahb_burst_in);
   assign blen     = burst_len_m1(burst);
   assign lock_own = mst_lock_in[addr_q];
   assign req_own  = mst_req_in[addr_q];

   ahb_rr_picker #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_picker (
      .req   (mst_req_in),
      .ptr   (ptr_q),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   always_comb begin
      win_idx = DEF_IDX;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (pick_gnt[i]) win_idx = IW'(i);
      new_idx = pick_valid ? win_idx : DEF_IDX;
      gnt_n = '0;
      gnt_n[new_idx] = 1'b1;
   end

   always_comb begin
      st_n  = st_q;
      cnt_n = cnt_q;
      rearb = 1'b0;
      unique case (st_q)
         ST_ARB: begin
            if (trans == HTRANS_NONSEQ && blen != 4'd0) begin
               st_n  = ST_BURST;
               cnt_n = blen;
            end else if (trans == HTRANS_NONSEQ &&
                         burst == HBURST_INCR) begin
               st_n = ST_INCR;
            end else begin
               rearb = 1'b1;
            end
         end
         ST_BURST: begin
            if (trans == HTRANS_SEQ) begin
               cnt_n = cnt_q - 4'd1;
               rearb = (cnt_q <= 4'd1);
            end else if (trans != HTRANS_BUSY) begin
               rearb = 1'b1;
            end
         end
         ST_INCR:
            rearb = !req_own && (trans == HTRANS_IDLE ||
                                 trans == HTRANS_NONSEQ);
         ST_LOCKED:
            rearb = !lock_own && trans == HTRANS_IDLE;
         default: st_n = ST_ARB;
      endcase
      // A still-locked owner keeps the bus instead of handing it over
      if (lock_own && (rearb || st_q == ST_ARB)) begin
         rearb = 1'b0;
         st_n  = ST_LOCKED;
         cnt_n = 4'd0;
      end
      if (rearb) begin
         st_n  = mst_lock_in[new_idx] ? ST_LOCKED : ST_ARB;
         cnt_n = 4'd0;
      end
   end

   always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
      if (!ahb_rstn_in) begin
         st_q   <= ST_ARB;
         cnt_q  <= '0;
         gnt_q  <= DEF_GNT;
         addr_q <= DEF_IDX;
         data_q <= DEF_IDX;
         ptr_q  <= DEF_IDX;
         lock_q <= 1'b0;
      end else if (ahb_ready_in) begin
         st_q   <= st_n;
         cnt_q  <= cnt_n;
         data_q <= addr_q;
         lock_q <= (st_n == ST_LOCKED);
         if (rearb) begin
            gnt_q  <= gnt_n;
            addr_q <= new_idx;
            if (pick_valid) ptr_q <= win_idx;
         end
      end
   end

   assign mst_grant_out    = gnt_q;
   assign addr_master_out  = addr_q;
   assign data_master_out  = data_q;
   assign ahb_mastlock_out = lock_q;

endmodule
